cmd_seq_encoder: RTL

//  Command-side front end of the DDR3 PHY: accepts one DDR3 command per valid/ready handshake and

---
 rtl/ddr3_phy_pkg.sv | 25 ++
 rtl/cmd_seq_encoder.sv | 130 +++++++++++++
 2 files changed

// File: rtl/ddr3_phy_pkg.sv
// Shared DDR3 PHY definitions: {ras,cas,we} command encodings, the command-sequencer state
// type, and the helper that places a control bit in one clk half.
package ddr3_phy_pkg;

    localparam logic [2:0] RCW_NOP = 3'b111;
    localparam logic [2:0] RCW_ACT = 3'b011;
    localparam logic [2:0] RCW_RD  = 3'b101;
    localparam logic [2:0] RCW_WR  = 3'b100;
    localparam logic [2:0] RCW_PRE = 3'b010;
    localparam logic [2:0] RCW_REF = 3'b001;
    localparam logic [2:0] RCW_MRS = 3'b000;
    localparam logic [2:0] RCW_ZQ  = 3'b110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } seq_state_e;

    // bit 0 = first half, bit 1 = second half; the unused half idles high (inactive).
    function automatic logic [1:0] place_half(input logic bit_v, input logic slot);
        return slot ? {bit_v, 1'b1} : {1'b1, bit_v};
    endfunction

endpackage

// File: rtl/cmd_seq_encoder.sv
// Accepts one DDR3 command per handshake and encodes it into 2-bit-per-signal (first, second
// half) streams for cmd_addr, followed by a programmable NOP tail. All outputs registered.
module cmd_seq_encoder
    import ddr3_phy_pkg::*;
#(
    parameter int unsigned ADDRESS_NUMBER = 15,
    parameter int unsigned NOP_WIDTH      = 8,
    parameter bit          CKE_RESET      = 1'b0
) (
    input  logic                          clk_div,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [ADDRESS_NUMBER-1:0]     cmd_a,
    input  logic [2:0]                    cmd_ba,
    input  logic [2:0]                    cmd_rcw,
    input  logic                          cmd_slot,
    input  logic                          cmd_cke,
    input  logic                          cmd_odt,
    input  logic                          cmd_tri,
    input  logic [NOP_WIDTH-1:0]          cmd_nop,
    output logic                          busy,
    output logic [2*ADDRESS_NUMBER-1:0]   in_a,
    output logic [5:0]                    in_ba,
    output logic [1:0]                    in_we,
    output logic [1:0]                    in_ras,
    output logic [1:0]                    in_cas,
    output logic [1:0]                    in_cke,
    output logic [1:0]                    in_odt,
    output logic [1:0]                    in_tri
);

    seq_state_e                    state_q, state_d;
    logic [NOP_WIDTH-1:0]          cnt_q, cnt_d;
    logic [2*ADDRESS_NUMBER-1:0]   a_q, a_d;
    logic [5:0]                    ba_q, ba_d;
    logic [1:0]                    ras_q, ras_d;
    logic [1:0]                    cas_q, cas_d;
    logic [1:0]                    we_q, we_d;
    logic [1:0]                    cke_q, cke_d;
    logic [1:0]                    odt_q, odt_d;
    logic [1:0]                    tri_q, tri_d;

    logic [2*ADDRESS_NUMBER-1:0]   a_dup;
    logic [5:0]                    ba_dup;
    logic                          accept;

    for (genvar i = 0; i < ADDRESS_NUMBER; i++) begin : g_a_dup
        assign a_dup[2*i +: 2] = {2{cmd_a[i]}};
    end

    for (genvar i = 0; i < 3; i++) begin : g_ba_dup
        assign ba_dup[2*i +: 2] = {2{cmd_ba[i]}};
    end

    // A new command may land in the same cycle the previous tail expires (zero bubble).
    assign cmd_ready = rst_n & enable & ((state_q == IDLE) | (cnt_q == '0));
    assign accept    = cmd_valid & cmd_ready;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        ba_d    = ba_q;
        ras_d   = {2{RCW_NOP[2]}};
        cas_d   = {2{RCW_NOP[1]}};
        we_d    = {2{RCW_NOP[0]}};
        cke_d   = cke_q;
        odt_d   = odt_q;
        tri_d   = tri_q;

        if (accept) begin
            state_d = ISSUE;
            cnt_d   = cmd_nop;
            a_d     = a_dup;
            ba_d    = ba_dup;
            ras_d   = place_half(cmd_rcw[2], cmd_slot);
            cas_d   = place_half(cmd_rcw[1], cmd_slot);
            we_d    = place_half(cmd_rcw[0], cmd_slot);
            cke_d   = {2{cmd_cke}};
            odt_d   = {2{cmd_odt}};
            tri_d   = {2{cmd_tri}};
        end else if (state_q != IDLE) begin
            if (cnt_q != '0) begin
                cnt_d   = cnt_q - NOP_WIDTH'(1);
                state_d = WAIT;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            ba_q    <= '0;
            ras_q   <= 2'b11;
            cas_q   <= 2'b11;
            we_q    <= 2'b11;
            cke_q   <= {2{CKE_RESET}};
            odt_q   <= 2'b00;
            tri_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            ba_q    <= ba_d;
            ras_q   <= ras_d;
            cas_q   <= cas_d;
            we_q    <= we_d;
            cke_q   <= cke_d;
            odt_q   <= odt_d;
            tri_q   <= tri_d;
        end
    end

    assign in_a   = a_q;
    assign in_ba  = ba_q;
    assign in_ras = ras_q;
    assign in_cas = cas_q;
    assign in_we  = we_q;
    assign in_cke = cke_q;
    assign in_odt = odt_q;
    assign in_tri = tri_q;

endmodule
